// File: rtl/stage_wb_pkg.sv
// Shared widths and constants for the memory/write-back stage.
package stage_wb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 64;

    // Architectural zero register; writes to it are dropped at capture.
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/retire_counter.sv
// Free-running wrap-around event counter, cleared asynchronously.
module retire_counter
    import stage_wb_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stage_wb.sv
// Memory/write-back pipeline register, write-back mux and retired-instruction counter.
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              me_valid,
    input  logic              me_regs_write,
    input  logic              me_mem2reg,
    input  logic [REG_AW-1:0] me_rd,
    input  logic [DATA_W-1:0] me_alu_o,
    input  logic [DATA_W-1:0] me_mem_data,
    input  logic [DATA_W-1:0] me_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_valid,
    output logic              w_regs_write,
    output logic [REG_AW-1:0] w_regs_addr,
    output logic [DATA_W-1:0] w_regs_data,
    output logic [DATA_W-1:0] wb_pc,
    output logic [CNT_W-1:0]  instret
);

    logic [DATA_W-1:0] wb_data_d;
    logic              wb_write_d;
    logic              retire;

    always_comb begin
        wb_data_d  = me_mem2reg ? me_mem_data : me_alu_o;
        wb_write_d = me_valid & me_regs_write & (me_rd != REG_AW'(REG_X0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            w_regs_write <= 1'b0;
            w_regs_addr  <= '0;
            w_regs_data  <= '0;
            wb_pc        <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            w_regs_write <= 1'b0;
            w_regs_addr  <= '0;
            w_regs_data  <= '0;
            wb_pc        <= '0;
        end else if (!stall) begin
            wb_valid     <= me_valid;
            w_regs_write <= wb_write_d;
            w_regs_addr  <= me_rd;
            w_regs_data  <= wb_data_d;
            wb_pc        <= me_pc;
        end
    end

    // An entry is counted on the edge it leaves, so long stalls count it once.
    assign retire = wb_valid & (flush | ~stall);

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (retire),
        .count(instret)
    );

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
Memory/write-back pipeline register plus write-back stage. It captures the memory-stage result each cycle and selects ALU or load data as the write-back value. It drives the register-file write port and the forwarding bus that the memory and execute stages use. It also keeps a retired-instruction counter for debug and performance readout.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
me_valid  in  1  memory stage holds a real instruction
me_regs_write  in  1  instruction writes rd
me_mem2reg  in  1  1 = write-back load data, 0 = ALU result
me_rd  in  REG_AW  destination register
me_alu_o  in  DATA_W  ALU result from memory stage
me_mem_data  in  DATA_W  sign/zero-extended load data from memory stage
me_pc  in  DATA_W  instruction PC (debug)
stall  in  1  hold the write-back register contents
flush  in  1  insert a bubble into the write-back register
wb_valid  out  1  write-back register holds a real instruction
w_regs_write  out  1  register-file write enable (also forwarding enable)
w_regs_addr  out  REG_AW  register-file write address
w_regs_data  out  DATA_W  register-file write data (also forwarding data)
wb_pc  out  DATA_W  PC of the instruction in write-back
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): wb_valid, w_regs_write, w_regs_addr, w_regs_data, wb_pc and instret all go to 0 immediately. The first capture happens on the first rising edge after rst deasserts.
- All outputs are registered. Latency from me_* to w_* is one cycle. No combinational path from inputs to outputs.
- Next data value is computed before the register: me_mem2reg ? me_mem_data : me_alu_o.
- Next write enable is me_valid & me_regs_write & (me_rd != 0). x0 writes are suppressed at capture. wb_valid still follows me_valid.
- Update priority on each rising edge:
  - flush=1: wb_valid and w_regs_write go to 0; w_regs_addr, w_regs_data and wb_pc go to 0. Flush wins over stall.
  - stall=1 (flush=0): all write-back fields hold their values. The register file sees a repeated identical write, which is permitted and idempotent.
  - otherwise: capture the me_* values as above.
- Departure: the current write-back entry departs on an edge where flush=1 or stall=0.
- instret increments by 1 on an edge where wb_valid=1 and the entry departs. Each instruction is counted exactly once, however long it is stalled.
- instret wraps modulo 2^CNT_W with no saturation and no flag.
- A bubble (me_valid=0) captures as wb_valid=0 and w_regs_write=0; data fields take the mux value and are don't-care.
- me_valid=0 with me_regs_write=1 never produces a write.
- Mid-operation reset: asynchronous clear of every register, including instret. No pending state survives.

Decomposition:
- Shared package/define header: DATA_W, REG_AW and CNT_W defaults, plus the constant for register x0 (5'd0).
- Sub-module retire_counter (CNT_W, inc, count): clean unit, reusable for a cycle counter.
- The write-back register and mux stay inline.

Test Plan:
1. Reset mid-stream: assert rst=0 while wb_valid=1 and instret=5 -> all outputs 0 in the same cycle, before any clock edge.
2. ALU write-back: me_valid=1, me_regs_write=1, me_mem2reg=0, me_rd=7, me_alu_o=0x0000_1234 -> next cycle w_regs_write=1, w_regs_addr=7, w_regs_data=0x1234, and instret goes 0->1 on the following departing edge.
3. Load write-back and x0 suppression:
   - me_mem2reg=1, me_mem_data=0xFFFF_FF80, me_alu_o=0xDEAD_BEEF, me_rd=3 -> w_regs_data=0xFFFF_FF80.
   - Repeat with me_rd=0 -> w_regs_write=0, wb_valid=1, instret still increments.
4. Stall hold: capture rd=5/data=0xA5 with stall=1 for 3 cycles while me_* changes -> outputs stay rd=5/0xA5 for all 3 cycles; instret increases by exactly 1 once stall drops.
5. Flush over stall: stall=1 and flush=1 together with wb_valid=1 -> next cycle wb_valid=0, w_regs_write=0, w_regs_data=0; instret increments by 1.
6. Counter wrap: CNT_W=4, retire 17 consecutive valid instructions with no stall -> instret reads 1 with no other side effects.
